// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared types and constants for the seven-segment scan controller.
//   seg_t        : segment vector {a,b,c,d,e,f,g}, bit 6 = a, active high
//   SEG_BLANK    : all segments off
//   scan_state_t : scan FSM states
//   HEX7_TABLE   : hex nibble -> segment pattern
// -----------------------------------------------------------------------------
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Index = nibble value; glyphs 0-9, A, b, C, d, E, F.
  localparam seg_t HEX7_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctrl_if
// Valid/ready load port carrying a new display value into the scan controller.
//   load_valid : producer offers load_data/load_dp
//   load_ready : controller's pending buffer is empty
//   load_data  : 4*N_DIGITS hex nibbles, digit i = [4i+3:4i], digit 0 rightmost
//   load_dp    : per-digit decimal-point bits
// Modports: master = producer (bus/register side), slave = controller.
// -----------------------------------------------------------------------------
interface sevenseg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*N_DIGITS-1:0]   load_data;
  logic [N_DIGITS-1:0]     load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/sevenseg_scan_ctrl_hex7_decode.sv
// -----------------------------------------------------------------------------
// hex7_decode
// Combinational hex-to-seven-segment lookup.
//   nibble : 4-bit hex value
//   seg    : segment pattern {a..g}, active high
// -----------------------------------------------------------------------------
module hex7_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctrl
// Time-multiplexed scan controller for N_DIGITS common-cathode digits sharing
// one set of a..g lines. A value loaded over the valid/ready port waits in a
// one-deep pending buffer and is committed to the display register only while
// idle or at a frame boundary, so a frame never shows a torn value.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : scan enable; dropping it returns to IDLE on the next edge
//   load       : sevenseg_scan_ctrl_if.slave load port
//   seg        : segments {a..g}, active high
//   dp         : decimal point of the driven digit
//   an         : one-hot digit enable, non-zero only while driving a digit
//   frame_done : one-cycle pulse at the end of each complete scan
//
// Parameters: N_DIGITS (2..8), REFRESH_DIV (>=1 on-cycles per digit),
//             BLANK_CYC (dead cycles between digits, 0 = none).
// Frame length = N_DIGITS*(REFRESH_DIV+BLANK_CYC) cycles.
//
// Build option: define SEVENSEG_LEADING_ZERO_BLANK_EN to suppress leading
// zero digits (digit 0 and digits with dp set are always shown).
// -----------------------------------------------------------------------------
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  sevenseg_scan_ctrl_if.slave load,
  output seg_t                seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an,
  output logic                frame_done
);

  localparam int CNT_MAX    = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W      = $clog2(N_DIGITS);
  localparam int BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  scan_state_t             state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [4*N_DIGITS-1:0]   disp_data, disp_data_nxt, pend_data;
  logic [N_DIGITS-1:0]     disp_dp, disp_dp_nxt, pend_dp;
  logic                    pend_full;
  logic                    accept, commit, advance, frame_nxt;
  logic                    suppress, show;
  logic [3:0]              nibble;
  seg_t                    seg_dec;

  // Accept needs an empty buffer and commit needs a full one, so the two
  // can never coincide.
  assign load.load_ready = !pend_full;
  assign accept          = load.load_valid && !pend_full;

  // ---------------------------------------------------------------------------
  // Scan sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    advance   = 1'b0;
    frame_nxt = 1'b0;
    commit    = (state == IDLE) && pend_full;

    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DRIVE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        DRIVE: begin
          if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            if (BLANK_CYC > 0) begin
              state_nxt = BLANK;
              cnt_nxt   = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_LAST)) advance = 1'b1;
          else                           cnt_nxt = cnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase

      if (advance) begin
        state_nxt = DRIVE;
        cnt_nxt   = '0;
        if (idx == IDX_W'(N_DIGITS - 1)) begin
          idx_nxt   = '0;
          frame_nxt = 1'b1;
          commit    = pend_full;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
    end
  end

  // The outputs are registered alongside the state, so they are derived
  // from next-state values, including a value committed on this same edge.
  assign disp_data_nxt = commit ? pend_data : disp_data;
  assign disp_dp_nxt   = commit ? pend_dp   : disp_dp;
  assign nibble        = disp_data_nxt[{idx_nxt, 2'b00} +: 4];

  hex7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; upper_zero stays set while
  // this digit and all above it are zero. Digit 0 is never visited.
  logic upper_zero;
  always_comb begin
    suppress   = 1'b0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (disp_data_nxt[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx_nxt) suppress = upper_zero && !disp_dp_nxt[i];
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign show = (state_nxt == DRIVE) && !suppress;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      an         <= '0;
      seg        <= SEG_BLANK;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      an         <= show ? (N_DIGITS'(1) << idx_nxt) : '0;
      seg        <= show ? seg_dec : SEG_BLANK;
      dp         <= show && disp_dp_nxt[idx_nxt];
      frame_done <= frame_nxt;
    end
  end

  // NOTE: the display and pending registers are reset because their reset
  // contents are visible behaviour (blank display, empty buffer), not just
  // storage that gets overwritten before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
    end else begin
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      if (accept) begin
        pend_data <= load.load_data;
        pend_dp   <= load.load_dp;
      end
      pend_full <= accept || (pend_full && !commit);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
// Directed bench for sevenseg_scan_ctrl. Two instances: dut (N=4,
// REFRESH_DIV=4, BLANK_CYC=2, 24-cycle frame) and dut0 (BLANK_CYC=0,
// 16-cycle frame). Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;
  import sevenseg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en, en0;

  seg_t       seg, seg0;
  logic       dp, dp0;
  logic [3:0] an, an0;
  logic       frame_done, frame_done0;

  int n_vec = 0;
  int n_err = 0;

  sevenseg_scan_ctrl_if #(.N_DIGITS(4)) ld_if  ();
  sevenseg_scan_ctrl_if #(.N_DIGITS(4)) ld_if0 ();

  sevenseg_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (ld_if.slave),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  sevenseg_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en0),
    .load       (ld_if0.slave),
    .seg        (seg0),
    .dp         (dp0),
    .an         (an0),
    .frame_done (frame_done0)
  );

  always #5 clk = ~clk;

  // Hand-derived segment patterns, packed {digit3, digit2, digit1, digit0}.
  localparam logic [3:0][6:0] SEGS_12AF = {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111};
  localparam logic [3:0][6:0] SEGS_0000 = {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
  localparam logic [3:0][6:0] SEGS_0050 = {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110};

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] SHOW_0000_DP2 = 4'b0101;
  localparam logic [3:0] SHOW_0050     = 4'b0011;
`else
  localparam logic [3:0] SHOW_0000_DP2 = 4'b1111;
  localparam logic [3:0] SHOW_0050     = 4'b1111;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks ncyc cycles of dut starting at the current cycle (frame cycle 0).
  // fd0 is the expected frame_done on cycle 0. With inject set, a load is
  // offered mid-frame and a second offer is held while the buffer is full.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs,
                             input logic [3:0] show, input logic [3:0] dpm,
                             input int ncyc, input logic fd0, input logic inject);
    int         slot;
    logic       on;
    logic [3:0] exp_an;
    for (int c = 0; c < ncyc; c++) begin
      slot   = c / 6;
      on     = ((c % 6) < 4) && show[slot];
      exp_an = on ? 4'(1 << slot) : 4'h0;
      check($sformatf("%s_an_c%0d", tag, c), an, exp_an);
      check($sformatf("%s_seg_c%0d", tag, c), seg, on ? segs[slot] : 7'h00);
      check($sformatf("%s_dp_c%0d", tag, c), dp, on && dpm[slot]);
      check($sformatf("%s_fd_c%0d", tag, c), frame_done, (c == 0) ? fd0 : 1'b0);
      if (inject) begin
        if (c == 4) begin
          ld_if.load_valid = 1'b1;
          ld_if.load_data  = 16'h0000;
          ld_if.load_dp    = 4'b0100;
        end
        if (c == 5) begin
          check("ready_after_midframe_accept", ld_if.load_ready, 1'b0);
          ld_if.load_data = 16'h8888;
          ld_if.load_dp   = 4'b0000;
        end
        if (c == 20) begin
          check("ready_held_second_offer", ld_if.load_ready, 1'b0);
          ld_if.load_valid = 1'b0;
        end
      end
      if (c < ncyc - 1) tick();
    end
  endtask

  initial begin
    logic [3:0] exp_an0;
    int         slot0;

    rst_n = 1'b0;
    en    = 1'b0;
    en0   = 1'b0;
    ld_if.load_valid  = 1'b0;
    ld_if.load_data   = '0;
    ld_if.load_dp     = '0;
    ld_if0.load_valid = 1'b0;
    ld_if0.load_data  = '0;
    ld_if0.load_dp    = '0;

    // Reset state
    #12;
    check("rst_an", an, 4'h0);
    check("rst_seg", seg, 7'h00);
    check("rst_dp", dp, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ready", ld_if.load_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Load 12AF (dp on digit 2) while idle: accept, then commit in IDLE
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h12AF;
    ld_if.load_dp    = 4'b0100;
    tick();
    check("idle_accept_ready", ld_if.load_ready, 1'b0);
    ld_if.load_valid = 1'b0;
    tick();
    check("idle_commit_ready", ld_if.load_ready, 1'b1);
    check("idle_an", an, 4'h0);

    // Basic scan: first frame, no frame_done on its first cycle
    en = 1'b1;
    tick();
    check_frame("f1", SEGS_12AF, 4'b1111, 4'b0100, 24, 1'b0, 1'b0);

    // Frame 2: frame_done at cycle 24, display unchanged during a mid-frame load
    tick();
    check_frame("f2", SEGS_12AF, 4'b1111, 4'b0100, 24, 1'b1, 1'b1);

    // Frame 3: 0000 with dp on digit 2 committed at the boundary; drop en in digit 2
    tick();
    check("commit_ready_back", ld_if.load_ready, 1'b1);
    check_frame("f3", SEGS_0000, SHOW_0000_DP2, 4'b0100, 14, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    check("endrop_an", an, 4'h0);
    check("endrop_seg", seg, 7'h00);
    check("endrop_fd", frame_done, 1'b0);
    tick();
    check("idle_an_hold", an, 4'h0);
    check("idle_fd_hold", frame_done, 1'b0);

    // Load 0050 while idle, then restart: full frame before frame_done
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h0050;
    ld_if.load_dp    = 4'b0000;
    tick();
    check("lz_accept_ready", ld_if.load_ready, 1'b0);
    ld_if.load_valid = 1'b0;
    tick();
    check("lz_commit_ready", ld_if.load_ready, 1'b1);
    en = 1'b1;
    tick();
    check_frame("f4", SEGS_0050, SHOW_0050, 4'b0000, 24, 1'b0, 1'b0);

    // Accept on the frame-end edge, then reset asynchronously mid-DRIVE
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 16'h1234;
    tick();
    ld_if.load_valid = 1'b0;
    check("f4_end_fd", frame_done, 1'b1);
    check("f4_end_an", an, 4'h1);
    check("f4_end_seg", seg, 7'b1111110);
    check("f4_end_ready", ld_if.load_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_an", an, 4'h0);
    check("async_rst_seg", seg, 7'h00);
    check("async_rst_fd", frame_done, 1'b0);
    check("async_rst_ready", ld_if.load_ready, 1'b1);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // BLANK_CYC=0 instance: back-to-back digits, frame_done every 16 cycles
    ld_if0.load_valid = 1'b1;
    ld_if0.load_data  = 16'h12AF;
    ld_if0.load_dp    = 4'b0000;
    tick();
    ld_if0.load_valid = 1'b0;
    tick();
    en0 = 1'b1;
    tick();
    for (int c = 0; c <= 32; c++) begin
      slot0   = (c / 4) % 4;
      exp_an0 = 4'(1 << slot0);
      check($sformatf("nb_an_c%0d", c), an0, exp_an0);
      check($sformatf("nb_seg_c%0d", c), seg0, SEGS_12AF[slot0]);
      check($sformatf("nb_fd_c%0d", c), frame_done0, (c == 16) || (c == 32));
      if (c < 32) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
